// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the fetch PC sequencer: FSM state encodings,
// redirect priority codes, the redirect payload and the default vectors.
package mips_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR   = 32'h0000_0180;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  // Numeric order is the arbitration order: a larger code wins.
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_JMP  = 2'd1,
    PRI_BR   = 2'd2,
    PRI_EXC  = 2'd3
  } redir_pri_t;

  // One redirect request; epc is only meaningful for PRI_EXC.
  typedef struct packed {
    redir_pri_t      pri;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] epc;
  } redirect_t;

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/redirect_latch.sv
// One-entry pending redirect register with priority compare.
// Ports:
//   clk, clk_reset : clock, async active-low reset
//   req            : redirect arriving this cycle (pri PRI_NONE when idle)
//   load           : capture req if it is at least as urgent as the pending one
//   clear          : the selected redirect is being applied; drop the entry
//   pend           : registered pending entry
//   sel_c          : winner of req vs pend (req wins on equal priority)
//   accept_c       : req is valid and beats or ties the pending entry
module redirect_latch
  import mips_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      clk_reset,
  input  redirect_t req,
  input  logic      load,
  input  logic      clear,
  output redirect_t pend,
  output redirect_t sel_c,
  output logic      accept_c
);

  // A pending exception can only be displaced by another exception.
  assign accept_c = (req.pri != PRI_NONE) && (req.pri >= pend.pri);
  assign sel_c    = accept_c ? req : pend;

  // Pending entry storage.
  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      pend <= '0;
    end else if (clear) begin
      pend <= '0;
    end else if (load && accept_c) begin
      pend <= req;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: picks the address loaded into the PC register each
// cycle (sequential, hold, branch/jump/exception redirect) and drives fetch.
// Ports:
//   clk, clk_reset        : clock, async active-low reset
//   cur_pc                : current PC register value
//   next_pc               : combinational PC register input
//   imem_req / imem_ack   : fetch request at cur_pc / fetch done
//   stall                 : hazard, hold PC
//   br_*, jmp_*, exc_valid: redirect sources (exc > br > jmp)
//   halt / resume         : enter / leave HALTED
//   flush                 : combinational one-cycle squash on redirect apply
//   epc                   : registered captured exception PC
//   seq_state             : registered FSM state
module pc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic            clk,
  input  logic            clk_reset,
  input  logic [XLEN-1:0] cur_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            exc_valid,
  input  logic            halt,
  input  logic            resume,
  output logic            flush,
  output logic [XLEN-1:0] epc,
  output logic [1:0]      seq_state
);

  seq_state_t state, state_nxt;
  redirect_t  new_req, pend, sel;
  logic       accept, load, apply;

  // Build this cycle's highest-priority request; misaligned targets trap.
  always_comb begin
    new_req = '0;
    if (exc_valid) begin
      new_req.pri    = PRI_EXC;
      new_req.target = EXC_VECTOR;
      new_req.epc    = cur_pc;
    end else if (br_valid) begin
      if (is_misaligned(br_target[1:0])) begin
        new_req.pri    = PRI_EXC;
        new_req.target = EXC_VECTOR;
        new_req.epc    = br_target;
      end else begin
        new_req.pri    = PRI_BR;
        new_req.target = br_target;
      end
    end else if (jmp_valid) begin
      if (is_misaligned(jmp_target[1:0])) begin
        new_req.pri    = PRI_EXC;
        new_req.target = EXC_VECTOR;
        new_req.epc    = jmp_target;
      end else begin
        new_req.pri    = PRI_JMP;
        new_req.target = jmp_target;
      end
    end
  end

  redirect_latch u_redirect_latch (
    .clk      (clk),
    .clk_reset(clk_reset),
    .req      (new_req),
    .load     (load),
    .clear    (apply),
    .pend     (pend),
    .sel_c    (sel),
    .accept_c (accept)
  );

  // State register.
  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, next PC, fetch request and redirect apply/latch decisions.
  always_comb begin
    state_nxt = state;
    next_pc   = cur_pc;
    imem_req  = 1'b0;
    flush     = 1'b0;
    apply     = 1'b0;
    load      = 1'b0;
    case (state)
      ST_BOOT: begin
        next_pc   = RESET_VECTOR;
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !stall) begin
          if (sel.pri != PRI_NONE) begin
            next_pc = sel.target;
            flush   = 1'b1;
            apply   = 1'b1;
          end else begin
            next_pc = cur_pc + 32'd4;
            if (halt) begin
              state_nxt = ST_HALTED;
            end
          end
        end else begin
          load = 1'b1;
          if (stall) begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        load = 1'b1;
        if (!stall) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_HALTED: begin
        // Redirects take effect immediately here; they also outrank resume.
        if (sel.pri != PRI_NONE) begin
          next_pc   = sel.target;
          flush     = 1'b1;
          apply     = 1'b1;
          state_nxt = ST_FETCH;
        end else if (resume) begin
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Exception PC capture, on apply or when an exception becomes pending.
  always_ff @(posedge clk or negedge clk_reset) begin
    if (!clk_reset) begin
      epc <= '0;
    end else if (apply && (sel.pri == PRI_EXC)) begin
      epc <= sel.epc;
    end else if (load && accept && (new_req.pri == PRI_EXC)) begin
      epc <= new_req.epc;
    end
  end

  assign seq_state = state;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning first fetch address after reset.
REQ-002 The block SHALL have parameter EXC_VECTOR, default 32'h00000180, meaning exception handler address.
REQ-003 The block SHALL have these ports:
- clk  input  1  clock, all state updates on rising edge.
- clk_reset  input  1  reset, asynchronous, active-low.
- cur_pc  input  32  current PC from the PC register.
- next_pc  output  32  address loaded into the PC register every clk.
- imem_req  output  1  fetch request at cur_pc.
- imem_ack  input  1  fetch completed this cycle.
- stall  input  1  pipeline hazard; hold PC.
- br_valid  input  1  taken branch.
- br_target  input  32  branch target.
- jmp_valid  input  1  jump or jump-register.
- jmp_target  input  32  jump target.
- exc_valid  input  1  exception request.
- halt  input  1  stop fetching.
- resume  input  1  leave HALTED.
- flush  output  1  one-cycle squash of younger instructions.
- epc  output  32  captured exception PC.
- seq_state  output  2  encoded FSM state.

Function
REQ-004 FSM states SHALL be BOOT=0, FETCH=1, HOLD=2, HALTED=3.
REQ-005 The PC register loads every cycle, so next_pc SHALL equal cur_pc whenever the PC must hold; next_pc SHALL never be X.
REQ-006 BOOT SHALL last exactly one cycle with next_pc=RESET_VECTOR, then go to FETCH.
REQ-007 In FETCH, imem_req SHALL be 1; without imem_ack, next_pc=cur_pc.
REQ-008 In FETCH with imem_ack, stall=0 and no redirect, next_pc SHALL be cur_pc+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-009 Redirect priority SHALL be exc_valid > br_valid > jmp_valid; only the highest active source is taken in a cycle.
REQ-010 A redirect is applied when imem_ack=1 and stall=0, or immediately in HALTED: next_pc=target, flush=1 for that cycle only.
REQ-011 A redirect arriving with imem_ack=0 or stall=1 SHALL be latched into a one-entry pending register; FSM goes to HOLD when stall=1; next_pc=cur_pc.
REQ-012 A new redirect SHALL overwrite the pending entry only if its priority is equal or higher; a pending exception is never overwritten by branch or jump.
REQ-013 Pending redirect SHALL be applied on the first cycle meeting REQ-010, then cleared; a simultaneous new redirect in that cycle is resolved by REQ-009 against the pending one.
REQ-014 HOLD SHALL keep next_pc=cur_pc and imem_req=0 until stall=0, then return to FETCH (a pending redirect is applied on its next ack).
REQ-015 Exception: epc SHALL capture cur_pc when the exception is accepted (pending or applied); target=EXC_VECTOR.
REQ-016 A branch or jump target with bits[1:0] != 0 SHALL be converted into an exception with epc=that target.
REQ-017 halt=1 with imem_ack=1 in FETCH and no redirect SHALL go to HALTED, next_pc=cur_pc+4; HALTED holds PC with imem_req=0.
REQ-018 In HALTED, resume=1 SHALL go to FETCH; exc_valid=1 SHALL apply the exception and go to FETCH; exception wins over resume.
REQ-019 flush SHALL be registered-free combinational from the apply condition but never asserted in BOOT or HOLD.

Reset
REQ-020 On clk_reset=0, the block SHALL asynchronously set state=BOOT, next_pc=RESET_VECTOR, imem_req=0, flush=0, epc=0, and clear the pending register.
REQ-021 Reset mid-HOLD or with a redirect pending SHALL discard the pending redirect; after release, fetch starts at RESET_VECTOR.

Structure
REQ-022 State encodings, redirect-priority codes and the default vectors SHALL live in a shared package (mips_ctrl_pkg).
REQ-023 The one-entry pending redirect register with its priority compare SHALL be a sub-module named redirect_latch.

Verification
REQ-024 Reset release, imem_ack every cycle: next_pc sequence 0, 4, 8, 12; flush never 1.
REQ-025 cur_pc=0x10, br_valid with br_target=0x40 and imem_ack=0: next_pc holds 0x10; next ack cycle gives next_pc=0x40 and flush=1 for one cycle.
REQ-026 Same cycle exc_valid and br_valid at cur_pc=0x20: next_pc=0x180, epc=0x20, branch dropped.
REQ-027 stall=1 for 3 cycles while jmp_target=0x100 arrives: PC held 3 cycles in HOLD; after stall drops and ack, next_pc=0x100.
REQ-028 cur_pc=0xFFFFFFFC with ack: next_pc=0x0; br_target=0x42: next_pc=0x180, epc=0x42.
REQ-029 halt at cur_pc=0x8: HALTED at 0xC, imem_req=0; resume -> fetch resumes at 0xC; reset asserted during HOLD -> next_pc=0 immediately.
